// File: rtl/prism_aux_datapath.sv
// PRISM auxiliary datapath: down-counters, up-counter with compare,
// bidirectional shift register, output latch and sticky interrupts.
module prism_aux_datapath #(
  parameter int NCNT    = 2,
  parameter int CNT_W   = 24,
  parameter int UCNT_W  = 5,
  parameter int SHIFT_W = 32,
  parameter int LATCH_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exec,
  input  logic [NCNT-1:0]    ctrl_load,
  input  logic [NCNT-1:0]    ctrl_dec,
  input  logic               ctrl_inc,
  input  logic               ctrl_clr,
  input  logic               ctrl_shift,
  input  logic               ctrl_latch,
  input  logic [LATCH_W-1:0] fsm_out,
  input  logic [3:0]         pins_in,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_wr,
  output logic [31:0]        reg_rdata,
  output logic [NCNT-1:0]    cnt_zero,
  output logic               ucnt_match,
  output logic               shift_done,
  output logic               shift_bit,
  output logic [LATCH_W-1:0] latched_out,
  output logic               irq
);

  logic [CNT_W-1:0]   cnt [NCNT];
  logic [CNT_W-1:0]   pre [NCNT];
  logic [UCNT_W-1:0]  ucnt;
  logic [UCNT_W-1:0]  compare;
  logic [SHIFT_W-1:0] shreg;
  logic [5:0]         bit_cnt;
  logic [1:0]         in_sel;
  logic               dir;
  logic [5:0]         len;
  logic               en_match;
  logic               en_done;
  logic [2:0]         pending;
  logic               prev_match;

  logic               wr_cfg;
  logic               wr_shift;
  logic               wr_ucnt;
  logic [NCNT-1:0]    wr_cnt;
  logic               inc_e;
  logic               clr_e;
  logic               do_shift;
  logic               wrap;
  logic               pin;
  logic [5:0]         eff_len;
  logic [SHIFT_W-1:0] mask;
  logic [SHIFT_W-1:0] top;
  logic [SHIFT_W-1:0] sh_nx;
  logic [2:0]         pend_set;
  logic [2:0]         pend_nx;

  assign wr_cfg   = reg_wr && (reg_addr == 6'h00);
  assign wr_shift = reg_wr && (reg_addr == 6'h04);
  assign wr_ucnt  = reg_wr && (reg_addr == 6'h18);
  assign inc_e    = exec & ctrl_inc;
  assign clr_e    = exec & ctrl_clr;
  assign do_shift = exec & ctrl_shift & ~wr_shift;
  assign pin      = pins_in[in_sel];

  assign ucnt_match  = (ucnt == compare);
  assign shift_done  = (bit_cnt == 6'd0);
  assign irq         = |pending;

  // Effective shift length, masks and next shift value
  always_comb begin
    if (len == 6'd0 || len > 6'(SHIFT_W)) eff_len = 6'(SHIFT_W);
    else eff_len = len;
    for (int i = 0; i < SHIFT_W; i++) begin
      mask[i] = (i < int'(eff_len));
      top[i]  = (i == int'(eff_len) - 1);
    end
    if (dir)
      sh_nx = ((shreg >> 1) & ~top) | (top & {SHIFT_W{pin}});
    else
      sh_nx = {shreg[SHIFT_W-2:0], pin};
    sh_nx = sh_nx & mask;
    shift_bit = dir ? shreg[0] : |(shreg & top);
    wrap = (bit_cnt >= eff_len - 6'd1);
  end

  // Interrupt set/clear; a set in the clearing cycle wins
  always_comb begin
    pend_set[0] = en_match & ucnt_match & ~prev_match;
    pend_set[1] = do_shift & wrap & en_done;
    pend_set[2] = inc_e & clr_e;
    pend_nx = (wr_cfg && reg_wdata[31]) ? 3'b000 : pending;
    pend_nx = pend_nx | pend_set;
  end

  // Per-counter write strobes and zero flags
  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      wr_cnt[i]   = reg_wr && (reg_addr == 6'(8 + 4 * i));
      cnt_zero[i] = (cnt[i] == '0);
    end
  end

  // Down-counters and their preload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt[i] <= '0;
        pre[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (wr_cnt[i]) pre[i] <= reg_wdata[CNT_W-1:0];
        if (exec && ctrl_load[i]) cnt[i] <= pre[i];
        else if (exec && ctrl_dec[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  // Config, shift, up-counter, latch and interrupt state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_sel      <= '0;
      dir         <= 1'b0;
      len         <= '0;
      en_match    <= 1'b0;
      en_done     <= 1'b0;
      pending     <= '0;
      prev_match  <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      compare     <= '0;
      ucnt        <= '0;
      latched_out <= '0;
    end else begin
      if (wr_cfg) begin
        in_sel   <= reg_wdata[1:0];
        dir      <= reg_wdata[2];
        len      <= reg_wdata[8:3];
        en_match <= reg_wdata[16];
        en_done  <= reg_wdata[17];
      end
      pending    <= pend_nx;
      prev_match <= ucnt_match;
      if (wr_shift) begin
        shreg   <= reg_wdata[SHIFT_W-1:0];
        bit_cnt <= '0;
      end else if (do_shift) begin
        shreg   <= sh_nx;
        bit_cnt <= wrap ? 6'd0 : bit_cnt + 6'd1;
      end
      if (wr_ucnt) compare <= reg_wdata[UCNT_W-1:0];
      if (inc_e && !clr_e) ucnt <= ucnt + UCNT_W'(1);
      else if (clr_e && !inc_e) ucnt <= '0;
      if (exec && ctrl_latch) latched_out <= fsm_out;
    end
  end

  // Zero-wait register read mux
  always_comb begin
    reg_rdata = 32'h0;
    case (reg_addr)
      6'h00: reg_rdata = {5'b0, pending, 6'b0, en_done,
                          en_match, 7'b0, len, dir, in_sel};
      6'h04: reg_rdata = 32'(shreg);
      6'h18: reg_rdata = {16'(compare), 16'(ucnt)};
      default: begin
        for (int i = 0; i < NCNT; i++)
          if (reg_addr == 6'(8 + 4 * i)) reg_rdata = 32'(cnt[i]);
      end
    endcase
  end

endmodule

// File: tb/tb_prism_aux_datapath.sv
// Scoreboard bench for prism_aux_datapath: stimulus queues expected
// observations, a negedge monitor pops and compares them.
module tb_prism_aux_datapath;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec;
  logic [1:0]  ctrl_load;
  logic [1:0]  ctrl_dec;
  logic        ctrl_inc;
  logic        ctrl_clr;
  logic        ctrl_shift;
  logic        ctrl_latch;
  logic [1:0]  fsm_out;
  logic [3:0]  pins_in;
  logic [5:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic [31:0] reg_rdata;
  logic [1:0]  cnt_zero;
  logic        ucnt_match;
  logic        shift_done;
  logic        shift_bit;
  logic [1:0]  latched_out;
  logic        irq;

  prism_aux_datapath dut (
    .clk(clk), .rst_n(rst_n), .exec(exec),
    .ctrl_load(ctrl_load), .ctrl_dec(ctrl_dec),
    .ctrl_inc(ctrl_inc), .ctrl_clr(ctrl_clr),
    .ctrl_shift(ctrl_shift), .ctrl_latch(ctrl_latch),
    .fsm_out(fsm_out), .pins_in(pins_in),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr(reg_wr), .reg_rdata(reg_rdata),
    .cnt_zero(cnt_zero), .ucnt_match(ucnt_match),
    .shift_done(shift_done), .shift_bit(shift_bit),
    .latched_out(latched_out), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam int RD = 0, CZ = 1, UM = 2, SD = 3;
  localparam int SB = 4, LO = 5, IRQ = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      RD:      return reg_rdata;
      CZ:      return 32'(cnt_zero);
      UM:      return 32'(ucnt_match);
      SD:      return 32'(shift_done);
      SB:      return 32'(shift_bit);
      LO:      return 32'(latched_out);
      default: return 32'(irq);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      act = obs(e.sel);
      n_cmp++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(int sel, logic [31:0] exp, string name);
    exp_t t;
    t.sel = sel;
    t.exp = exp;
    t.name = name;
    q.push_back(t);
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wr    = 1'b1;
    step();
    reg_wr    = 1'b0;
  endtask

  logic [7:0]  stream = 8'b1011_0010;
  logic [31:0] seq [5] = '{3, 2, 1, 0, 0};

  initial begin
    rst_n = 1'b0; exec = 1'b0;
    ctrl_load = '0; ctrl_dec = '0;
    ctrl_inc = 1'b0; ctrl_clr = 1'b0;
    ctrl_shift = 1'b0; ctrl_latch = 1'b0;
    fsm_out = '0; pins_in = '0;
    reg_addr = '0; reg_wdata = '0; reg_wr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk(RD, 32'h0, "rst_cfg");
    chk(CZ, 32'h3, "rst_cnt_zero");
    chk(UM, 32'h1, "rst_ucnt_match");
    chk(SD, 32'h1, "rst_shift_done");
    chk(SB, 32'h0, "rst_shift_bit");
    chk(LO, 32'h0, "rst_latched");
    chk(IRQ, 32'h0, "rst_irq");
    step();

    // down-counter: preload only, then load + decrement
    exec = 1'b1;
    wr(6'h08, 32'd3);
    reg_addr = 6'h08;
    chk(RD, 32'd0, "cnt0_preload_only");
    step();
    ctrl_dec = 2'b01;
    for (int k = 0; k < 5; k++) begin
      ctrl_load = (k == 0) ? 2'b01 : 2'b00;
      step();
      chk(RD, seq[k], "cnt0_seq");
      chk(CZ, {30'b0, 1'b1, seq[k] == 0}, "cnt0_zero");
    end
    ctrl_dec = 2'b00;
    ctrl_load = 2'b01;
    step();
    exec = 1'b0;
    ctrl_dec = 2'b01;
    repeat (5) step();
    chk(RD, 32'd3, "cnt0_exec_low");
    ctrl_load = 2'b00; ctrl_dec = 2'b00;
    exec = 1'b1;
    step();

    // output latch
    fsm_out = 2'b10; ctrl_latch = 1'b1;
    step();
    chk(LO, 32'h2, "latch_capture");
    exec = 1'b0; fsm_out = 2'b01;
    step();
    chk(LO, 32'h2, "latch_exec_low");
    ctrl_latch = 1'b0; exec = 1'b1;

    // shift MSB-first, len 8, in_sel 2, en_done
    wr(6'h00, 32'h0002_0042);
    wr(6'h04, 32'h0);
    reg_addr = 6'h04;
    ctrl_shift = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pins_in = {1'b0, stream[7-k], 2'b00};
      step();
      if (k == 6) chk(SD, 32'h0, "sh_l_done_mid");
    end
    ctrl_shift = 1'b0;
    chk(RD, 32'hB2, "sh_left_val");
    chk(SD, 32'h1, "sh_left_done");
    chk(SB, 32'h1, "sh_left_bit");
    chk(IRQ, 32'h1, "sh_left_irq");
    step();
    reg_addr = 6'h00;
    chk(RD, 32'h0202_0042, "sh_left_cfg");
    step();

    // shift LSB-first, len 8, pending cleared
    wr(6'h00, 32'h8002_0046);
    chk(IRQ, 32'h0, "cfg_clear_irq");
    wr(6'h04, 32'h0);
    reg_addr = 6'h04;
    ctrl_shift = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pins_in = {1'b0, stream[7-k], 2'b00};
      step();
    end
    ctrl_shift = 1'b0;
    chk(RD, 32'h4D, "sh_right_val");
    chk(SB, 32'h1, "sh_right_bit");
    chk(SD, 32'h1, "sh_right_done");
    step();

    // len 0 means full 32-bit word
    wr(6'h00, 32'h8002_0006);
    wr(6'h04, 32'h0);
    pins_in = 4'h0;
    ctrl_shift = 1'b1;
    repeat (31) step();
    chk(SD, 32'h0, "sh_len0_31");
    step();
    chk(SD, 32'h1, "sh_len0_32");
    chk(IRQ, 32'h1, "sh_len0_irq");
    ctrl_shift = 1'b0;
    step();

    // up-counter compare and match interrupt
    wr(6'h00, 32'h8001_0000);
    chk(IRQ, 32'h0, "uc_clr_irq");
    wr(6'h18, 32'd4);
    step();
    ctrl_inc = 1'b1;
    repeat (4) step();
    ctrl_inc = 1'b0;
    chk(UM, 32'h1, "uc_match4");
    step();
    chk(IRQ, 32'h1, "uc_match_irq");
    reg_addr = 6'h18;
    chk(RD, 32'h0004_0004, "uc_read");
    step();
    wr(6'h00, 32'h8001_0000);
    chk(IRQ, 32'h0, "uc_irq_cleared");
    step();
    ctrl_inc = 1'b1;
    repeat (32) step();
    ctrl_inc = 1'b0;
    chk(UM, 32'h1, "uc_wrap_match");
    step();
    chk(IRQ, 32'h1, "uc_wrap_irq");
    reg_addr = 6'h00;
    chk(RD, 32'h0101_0000, "uc_wrap_pend");
    step();

    // inc & clr together with a pending clear
    reg_wdata = 32'h8001_0000; reg_wr = 1'b1;
    ctrl_inc = 1'b1; ctrl_clr = 1'b1;
    step();
    reg_wr = 1'b0; ctrl_inc = 1'b0; ctrl_clr = 1'b0;
    chk(IRQ, 32'h1, "incclr_irq");
    chk(RD, 32'h0401_0000, "incclr_pend");
    step();
    reg_addr = 6'h18;
    chk(RD, 32'h0004_0004, "incclr_count");
    step();
    ctrl_clr = 1'b1;
    step();
    ctrl_clr = 1'b0;
    chk(RD, 32'h0004_0000, "clr_count");
    step();

    // SHIFT write beats a same-cycle shift
    reg_addr = 6'h04; reg_wdata = 32'hA5; reg_wr = 1'b1;
    ctrl_shift = 1'b1; pins_in = 4'hF;
    step();
    reg_wr = 1'b0; ctrl_shift = 1'b0;
    chk(RD, 32'hA5, "shwr_val");
    chk(SD, 32'h1, "shwr_done");
    step();
    pins_in = 4'h0; ctrl_shift = 1'b1;
    repeat (3) step();
    ctrl_shift = 1'b0;
    chk(RD, 32'h528, "mid_word_val");
    chk(SD, 32'h0, "mid_word_done");
    chk(IRQ, 32'h1, "mid_word_irq");
    step();

    // asynchronous reset mid-word, checked before any clock edge
    #1;
    rst_n = 1'b0;
    #1;
    chk(RD, 32'h0, "arst_shreg");
    chk(SD, 32'h1, "arst_done");
    chk(CZ, 32'h3, "arst_cnt_zero");
    chk(UM, 32'h1, "arst_match");
    chk(IRQ, 32'h0, "arst_irq");
    chk(SB, 32'h0, "arst_bit");
    chk(LO, 32'h0, "arst_latched");
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10 && q.size() > 0; i++) step();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d want 0 queued", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
